risc_datapath_pipe: RTL

//  Parametrised, pipelined successor of the 16-bit RISC datapath. Contains a register

---
 rtl/risc_datapath_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/risc_datapath_pipe.sv
// Pipelined RISC datapath: 2R/1W register file, ALU with registered flags,
// writeback select and a single EX/WB stage with forwarding and stall.
module risc_datapath_pipe #(
    parameter int W       = 16,
    parameter int NREG    = 16,
    parameter int IMM_W   = 8,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic             stall,
    input  logic [AW-1:0]    rp_addr,
    input  logic [AW-1:0]    rq_addr,
    input  logic [2:0]       alu_s,
    input  logic [1:0]       wb_sel,
    input  logic             w_wr,
    input  logic [AW-1:0]    w_addr,
    input  logic [IMM_W-1:0] imm,
    input  logic [W-1:0]     mem_rdata,
    output logic [W-1:0]     rp_data,
    output logic [W-1:0]     rq_data,
    output logic             rp_zero,
    output logic             res_valid,
    output logic [W-1:0]     res_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    logic [W-1:0]  rf [NREG];
    logic          ex_w_wr;
    logic [AW-1:0] ex_w_addr;
    logic [W-1:0]  alu_y;
    logic          alu_c;
    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [W-1:0]  wb_data;
    logic [W-1:0]  imm_sext;
    logic          rf_we;

    function automatic logic is_r0(input logic [AW-1:0] addr);
        return (ZERO_R0 != 0) && (addr == '0);
    endfunction

    // A write to reg 0 is never forwarded when reg 0 is hard-wired to zero.
    function automatic logic [W-1:0] read_port(input logic [AW-1:0] addr,
                                              input logic          fwd_ok,
                                              input logic [AW-1:0] fwd_addr,
                                              input logic [W-1:0]  fwd_data,
                                              input logic [W-1:0]  rf_data);
        if (is_r0(addr))
            return '0;
        else if (fwd_ok && fwd_addr == addr)
            return fwd_data;
        else
            return rf_data;
    endfunction

    assign rp_data  = read_port(rp_addr, res_valid & ex_w_wr, ex_w_addr, res_data, rf[rp_addr]);
    assign rq_data  = read_port(rq_addr, res_valid & ex_w_wr, ex_w_addr, res_data, rf[rq_addr]);
    assign rp_zero  = (rp_data == '0);
    assign imm_sext = {{(W-IMM_W){imm[IMM_W-1]}}, imm};
    assign sum      = {1'b0, rp_data} + {1'b0, rq_data};
    assign diff     = {1'b0, rp_data} - {1'b0, rq_data};
    assign rf_we    = res_valid & ex_w_wr & ~stall & ~is_r0(ex_w_addr);

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        case (alu_s)
            3'b000: begin alu_y = sum[W-1:0];  alu_c = sum[W];  end
            3'b001: begin alu_y = diff[W-1:0]; alu_c = diff[W]; end
            3'b010: alu_y = rp_data & rq_data;
            3'b011: alu_y = rp_data | rq_data;
            3'b100: alu_y = rp_data ^ rq_data;
            3'b101: alu_y = ~rp_data;
            3'b110: begin alu_y = {rp_data[W-2:0], 1'b0};       alu_c = rp_data[W-1]; end
            default: begin alu_y = {rp_data[W-1], rp_data[W-1:1]}; alu_c = rp_data[0]; end
        endcase
    end

    always_comb begin
        wb_data = alu_y;
        case (wb_sel)
            2'b01:   wb_data = mem_rdata;
            2'b10:   wb_data = imm_sext;
            default: wb_data = alu_y;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            ex_w_wr   <= 1'b0;
            ex_w_addr <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
        end else if (!stall) begin
            res_valid <= op_valid;
            if (op_valid) begin
                res_data  <= wb_data;
                ex_w_wr   <= w_wr;
                ex_w_addr <= w_addr;
                flag_z    <= (alu_y == '0);
                flag_n    <= alu_y[W-1];
                flag_c    <= alu_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (rf_we) begin
            rf[ex_w_addr] <= res_data;
        end
    end

endmodule
